// File: rtl/int_to_float_pipe.sv
// Four-stage integer to IEEE-754 converter with valid/ready flow control.
// Stages: S1 sign/magnitude, S2 leading-zero count, S3 normalise and exponent,
// S4 round and pack into the output registers. Each stage advances as a unit.
module int_to_float_pipe #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_signed,
    input  logic                         in_rnd_trunc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0] out_data,
    output logic                         out_inexact,
    output logic                         out_zero
);

    localparam int unsigned LZC_WIDTH = $clog2(IN_WIDTH + 1);
    localparam int unsigned BIAS      = 2 ** (EXP_WIDTH - 1) - 1;
    // Fraction bits below the hidden one, padded with MAN_WIDTH+2 zeros so that
    // frac, guard and round always exist even for narrow inputs.
    localparam int unsigned EXT_WIDTH = IN_WIDTH + MAN_WIDTH + 1;

    logic advance;

    // Stage registers
    logic                 s1_valid, s1_sign, s1_trunc;
    logic [IN_WIDTH-1:0]  s1_mag;
    logic                 s2_valid, s2_sign, s2_trunc;
    logic [IN_WIDTH-1:0]  s2_mag;
    logic [LZC_WIDTH-1:0] s2_lzc;
    logic                 s3_valid, s3_sign, s3_trunc, s3_zero;
    logic [IN_WIDTH-2:0]  s3_frac;
    logic [EXP_WIDTH-1:0] s3_exp;

    // Combinational stage results
    logic                 in_neg;
    logic [IN_WIDTH-1:0]  in_mag;
    logic [LZC_WIDTH-1:0] lzc;
    logic [IN_WIDTH-1:0]  norm;
    logic [EXT_WIDTH-1:0] ext;
    logic [MAN_WIDTH-1:0] frac, frac_rnd;
    logic                 guard, rnd_bit, sticky, inc, carry;
    logic [EXP_WIDTH-1:0] exp_rnd;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance | rst;

    // Sign and magnitude; the most-negative value wraps to 2^(IN_WIDTH-1),
    // which is the correct magnitude when read as unsigned.
    always_comb begin
        in_neg = in_signed & in_data[IN_WIDTH-1];
        in_mag = in_neg ? (-in_data) : in_data;
    end

    // S1: capture operand magnitude and mode bits
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_trunc <= 1'b0;
            s1_mag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= in_neg;
            s1_trunc <= in_rnd_trunc;
            s1_mag   <= in_mag;
        end
    end

    // Leading-zero count; the highest set bit wins, zero gives IN_WIDTH
    always_comb begin
        lzc = LZC_WIDTH'(IN_WIDTH);
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (s1_mag[i]) begin
                lzc = LZC_WIDTH'(IN_WIDTH - 1 - i);
            end
        end
    end

    // S2: register magnitude with its leading-zero count
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_trunc <= 1'b0;
            s2_mag   <= '0;
            s2_lzc   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_trunc <= s1_trunc;
            s2_mag   <= s1_mag;
            s2_lzc   <= lzc;
        end
    end

    // Normalise so the hidden one lands on the MSB
    always_comb begin
        norm = s2_mag << s2_lzc;
    end

    // S3: split off the hidden bit and form the biased exponent.
    // A zero operand leaves no MSB after normalisation; its exponent is junk
    // and is overridden at packing time.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_trunc <= 1'b0;
            s3_zero  <= 1'b0;
            s3_frac  <= '0;
            s3_exp   <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sign  <= s2_sign;
            s3_trunc <= s2_trunc;
            s3_zero  <= ~norm[IN_WIDTH-1];
            s3_frac  <= norm[IN_WIDTH-2:0];
            s3_exp   <= EXP_WIDTH'(IN_WIDTH - 1 + BIAS - 32'(s2_lzc));
        end
    end

    // Extract frac/guard/round/sticky and apply the rounding increment
    always_comb begin
        ext     = {s3_frac, {(MAN_WIDTH + 2){1'b0}}};
        frac    = ext[EXT_WIDTH-1 -: MAN_WIDTH];
        guard   = ext[EXT_WIDTH-1-MAN_WIDTH];
        rnd_bit = ext[EXT_WIDTH-2-MAN_WIDTH];
        sticky  = |ext[EXT_WIDTH-3-MAN_WIDTH:0];
        inc     = ~s3_trunc & guard & (rnd_bit | sticky | frac[0]);
        {carry, frac_rnd} = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, inc};
        exp_rnd = s3_exp + {{(EXP_WIDTH - 1){1'b0}}, carry};
    end

    // S4: output registers; data only reloads on a valid item so the bus
    // stays quiet across bubbles and holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
            out_zero    <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                if (s3_zero) begin
                    out_data    <= '0;
                    out_inexact <= 1'b0;
                    out_zero    <= 1'b1;
                end else begin
                    out_data    <= {s3_sign, exp_rnd, frac_rnd};
                    out_inexact <= guard | rnd_bit | sticky;
                    out_zero    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Scoreboard bench: a 32/8/23 instance with random backpressure and a 16/5/10
// instance, both checked against an arithmetic reference conversion.
module tb_int_to_float_pipe;

    typedef struct packed {
        logic [63:0] data;
        logic        inexact;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0, a_in_signed = 1'b0, a_in_trunc = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_inexact, a_out_zero;
    logic        a_out_ready = 1'b1;
    logic [31:0] a_out_data;

    logic        b_in_valid = 1'b0, b_in_signed = 1'b0, b_in_trunc = 1'b0;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_inexact, b_out_zero;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_data;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rand_ready = 1'b0;

    int_to_float_pipe #(.IN_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_signed(a_in_signed), .in_rnd_trunc(a_in_trunc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_inexact(a_out_inexact), .out_zero(a_out_zero)
    );

    int_to_float_pipe #(.IN_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_signed(b_in_signed), .in_rnd_trunc(b_in_trunc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_inexact(b_out_inexact), .out_zero(b_out_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input bit inexact, input bit zero);
        exp_t r;
        r.data    = d;
        r.inexact = inexact;
        r.zero    = zero;
        return r;
    endfunction

    // Reference: exact magnitude, shift to mw+1 significant bits, round the
    // discarded remainder against half an ulp.
    function automatic exp_t ref_conv(input logic [63:0] din, input bit sg, input bit tr,
                                      input int iw, input int ew, input int mw);
        exp_t r;
        logic [64:0] mag, q, rem, half;
        logic [63:0] bias;
        bit neg;
        int e, sh;
        r    = '0;
        rem  = '0;
        mag  = {1'b0, din} & ((65'd1 << iw) - 65'd1);
        neg  = sg && mag[iw-1];
        if (neg) mag = (65'd1 << iw) - mag;
        if (mag == 65'd0) begin
            r.zero = 1'b1;
            return r;
        end
        e = 0;
        for (int i = 0; i < 65; i++) if (mag[i]) e = i;
        if (e <= mw) begin
            q = mag << (mw - e);
        end else begin
            sh   = e - mw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 65'd1 << (sh - 1);
            r.inexact = (rem != 65'd0);
            if (!tr && (rem > half || (rem == half && q[0]))) q = q + 65'd1;
        end
        if (q == (65'd1 << (mw + 1))) begin
            q = q >> 1;
            e++;
        end
        bias   = (64'd1 << (ew - 1)) - 64'd1;
        r.data = (64'(neg) << (ew + mw)) | ((64'(e) + bias) << mw) | 64'(q - (65'd1 << mw));
        return r;
    endfunction

    // Random backpressure on instance A
    always @(posedge clk) begin
        #1;
        a_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor A: pop and compare on every handshake, and check output hold
    logic        a_hold = 1'b0;
    logic [33:0] a_hold_val = '0;
    exp_t        a_exp;
    always @(negedge clk) begin
        if (rst) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_hold_valid", 64'(a_out_valid), 64'd1);
                check("a_hold_data", 64'({a_out_inexact, a_out_zero, a_out_data}),
                      64'(a_hold_val));
            end
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_out", 64'(a_out_valid), 64'd0);
                end else begin
                    a_exp = q_a.pop_front();
                    check("a_data", 64'(a_out_data), a_exp.data);
                    check("a_inexact", 64'(a_out_inexact), 64'(a_exp.inexact));
                    check("a_zero", 64'(a_out_zero), 64'(a_exp.zero));
                end
            end
            a_hold     = a_out_valid && !a_out_ready;
            a_hold_val = {a_out_inexact, a_out_zero, a_out_data};
        end
    end

    // Monitor B (always ready)
    exp_t b_exp;
    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_out", 64'(b_out_valid), 64'd0);
            end else begin
                b_exp = q_b.pop_front();
                check("b_data", 64'(b_out_data), b_exp.data);
                check("b_inexact", 64'(b_out_inexact), 64'(b_exp.inexact));
                check("b_zero", 64'(b_out_zero), 64'(b_exp.zero));
            end
        end
    end

    // Drive one item into A (called just after a rising edge); leaves in_valid high
    task automatic send_a(input logic [31:0] d, input bit sg, input bit tr, input exp_t e);
        a_in_data   = d;
        a_in_signed = sg;
        a_in_trunc  = tr;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_in_ready) begin
                q_a.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL a_accept_timeout: in_ready stayed low for 200 cycles");
    endtask

    task automatic send_b(input logic [15:0] d, input bit sg, input bit tr, input exp_t e);
        b_in_data   = d;
        b_in_signed = sg;
        b_in_trunc  = tr;
        b_in_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (b_in_ready) begin
                q_b.push_back(e);
                @(posedge clk);
                #1;
                b_in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL b_accept_timeout: in_ready stayed low for 200 cycles");
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("a_drained", 64'(q_a.size()), 64'd0);
        check("b_drained", 64'(q_b.size()), 64'd0);
    endtask

    // Single item into both idle instances; count edges until out_valid
    task automatic latency_test(input logic [31:0] da, input logic [15:0] db, input bit sg);
        int lat_a, lat_b;
        lat_a = 0;
        lat_b = 0;
        a_in_data = da; a_in_signed = sg; a_in_trunc = 1'b0; a_in_valid = 1'b1;
        b_in_data = db; b_in_signed = sg; b_in_trunc = 1'b0; b_in_valid = 1'b1;
        q_a.push_back(ref_conv({32'd0, da}, sg, 1'b0, 32, 8, 23));
        q_b.push_back(ref_conv({48'd0, db}, sg, 1'b0, 16, 5, 10));
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
            b_in_valid = 1'b0;
            @(negedge clk);
            if (a_out_valid && lat_a == 0) lat_a = k;
            if (b_out_valid && lat_b == 0) lat_b = k;
            if (lat_a != 0 && lat_b != 0) break;
        end
        check("a_latency", 64'(lat_a), 64'd4);
        check("b_latency", 64'(lat_b), 64'd4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] rb;
        bit sg, tr;

        // Reset state, including in_ready while reset is held
        rst = 1'b1;
        a_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_inexact", 64'(a_out_inexact), 64'd0);
        check("rst_out_zero", 64'(a_out_zero), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with hand-derived results
        send_a(32'h0000_0001, 1'b0, 1'b0, mk(64'h3F80_0000, 1'b0, 1'b0));
        send_a(32'hFFFF_FFFF, 1'b1, 1'b0, mk(64'hBF80_0000, 1'b0, 1'b0));
        send_a(32'h8000_0000, 1'b1, 1'b0, mk(64'hCF00_0000, 1'b0, 1'b0));
        send_a(32'h8000_0000, 1'b0, 1'b0, mk(64'h4F00_0000, 1'b0, 1'b0));
        send_a(32'h0100_0001, 1'b0, 1'b0, mk(64'h4B80_0000, 1'b1, 1'b0));
        send_a(32'h0100_0003, 1'b0, 1'b0, mk(64'h4B80_0002, 1'b1, 1'b0));
        send_a(32'h0100_0003, 1'b0, 1'b1, mk(64'h4B80_0001, 1'b1, 1'b0));
        send_a(32'hFFFF_FFFF, 1'b0, 1'b0, mk(64'h4F80_0000, 1'b1, 1'b0));
        send_a(32'hFFFF_FFFF, 1'b0, 1'b1, mk(64'h4F7F_FFFF, 1'b1, 1'b0));
        send_a(32'h0000_0000, 1'b1, 1'b0, mk(64'h0000_0000, 1'b0, 1'b1));
        a_in_valid = 1'b0;
        send_b(16'h8000, 1'b1, 1'b0, mk(64'hF800, 1'b0, 1'b0));
        send_b(16'h0001, 1'b0, 1'b0, mk(64'h3C00, 1'b0, 1'b0));
        send_b(16'hFFFF, 1'b1, 1'b0, mk(64'hBC00, 1'b0, 1'b0));
        send_b(16'h0000, 1'b0, 1'b0, mk(64'h0000, 1'b0, 1'b1));
        drain();

        // Random back-to-back stream with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom;
            if ($urandom_range(0, 3) == 0) r = r >> $urandom_range(1, 31);
            sg = 1'($urandom_range(0, 1));
            tr = 1'($urandom_range(0, 1));
            send_a(r, sg, tr, ref_conv({32'd0, r}, sg, tr, 32, 8, 23));
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rb = 16'($urandom);
            sg = 1'($urandom_range(0, 1));
            tr = 1'($urandom_range(0, 1));
            send_b(rb, sg, tr, ref_conv({48'd0, rb}, sg, tr, 16, 5, 10));
        end
        rand_ready = 1'b0;
        drain();

        latency_test(32'h0000_0005, 16'h0005, 1'b0);

        // Reset with three items in flight in both instances
        for (int i = 0; i < 3; i++) begin
            a_in_data = 32'h1234_5678 + 32'(i); a_in_signed = 1'b0; a_in_valid = 1'b1;
            b_in_data = 16'h0123 + 16'(i);      b_in_signed = 1'b0; b_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        check("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        check("rst_mid_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_mid_b_valid", 64'(b_out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        latency_test(32'h8000_0000, 16'h8000, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
